// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants, phase encoding and margin helpers for the
// timing generator and the colour-assignment stage.
package vga_timing_gen_pkg;

    localparam int DEF_REZ_MAX_WIDTH = 11;
    localparam int DEF_H_SYNC        = 96;
    localparam int DEF_H_BP          = 48;
    localparam int DEF_H_ACTIVE      = 640;
    localparam int DEF_H_FP          = 16;
    localparam int DEF_V_SYNC        = 2;
    localparam int DEF_V_BP          = 33;
    localparam int DEF_V_ACTIVE      = 480;
    localparam int DEF_V_FP          = 10;

    typedef enum logic [1:0] {
        PH_SYNC  = 2'd0,
        PH_BACK  = 2'd1,
        PH_ACT   = 2'd2,
        PH_FRONT = 2'd3
    } phase_t;

    function automatic int left_margin(int sync, int bp);
        return sync + bp;
    endfunction

    function automatic int right_margin(int sync, int bp, int act);
        return sync + bp + act;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus sync/back/active/front phase FSM.
// Phase is registered alongside the count so both describe the same pixel.
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int W      = 11,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int ACTIVE = 640,
    parameter int FP     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] count,
    output phase_t       phase,
    output logic         wrap
);

    localparam int TOTAL = SYNC + BP + ACTIVE + FP;

    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_END = W'(SYNC - 1);
    localparam logic [W-1:0] BP_END   = W'(left_margin(SYNC, BP) - 1);
    localparam logic [W-1:0] ACT_END  = W'(right_margin(SYNC, BP, ACTIVE) - 1);

    phase_t phase_nxt;

    assign wrap = step && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            phase <= PH_SYNC;
        end else if (step) begin
            count <= wrap ? '0 : count + W'(1);
            phase <= phase_nxt;
        end
    end

    // Transition on the last position of each phase.
    always_comb begin
        phase_nxt = phase;
        unique case (phase)
            PH_SYNC:  if (count == SYNC_END) phase_nxt = PH_BACK;
            PH_BACK:  if (count == BP_END)   phase_nxt = PH_ACT;
            PH_ACT:   if (count == ACT_END)  phase_nxt = PH_FRONT;
            PH_FRONT: if (count == LAST)     phase_nxt = PH_SYNC;
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate divider driving horizontal and
// vertical axis counters, with sync/active decode and frame strobes.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   REZ_MAX_WIDTH = DEF_REZ_MAX_WIDTH,
    parameter int   CLK_DIV       = 2,
    parameter int   H_SYNC        = DEF_H_SYNC,
    parameter int   H_BP          = DEF_H_BP,
    parameter int   H_ACTIVE      = DEF_H_ACTIVE,
    parameter int   H_FP          = DEF_H_FP,
    parameter int   V_SYNC        = DEF_V_SYNC,
    parameter int   V_BP          = DEF_V_BP,
    parameter int   V_ACTIVE      = DEF_V_ACTIVE,
    parameter int   V_FP          = DEF_V_FP,
    parameter logic SYNC_POL      = 1'b0
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     En,
    output logic [REZ_MAX_WIDTH-1:0] Count_h,
    output logic [REZ_MAX_WIDTH-1:0] Count_v,
    output logic                     H_sync,
    output logic                     V_sync,
    output logic                     Active,
    output logic                     Pix_tick,
    output logic                     Line_end,
    output logic                     Frame_start
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          h_wrap;
    logic          v_wrap;
    logic          fs_q;
    phase_t        h_phase;
    phase_t        v_phase;

    assign tick = En && !Rst && (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else if (En) begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    vga_axis_counter #(
        .W      (REZ_MAX_WIDTH),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP)
    ) u_h_axis (
        .clk   (Clk),
        .rst   (Rst),
        .step  (tick),
        .count (Count_h),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .W      (REZ_MAX_WIDTH),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP)
    ) u_v_axis (
        .clk   (Clk),
        .rst   (Rst),
        .step  (h_wrap),
        .count (Count_v),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

    // Set on the edge that registers (0,0) so it lines up with the counts.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            fs_q <= 1'b0;
        end else begin
            fs_q <= v_wrap;
        end
    end

    assign H_sync      = (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign V_sync      = (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign Active      = (h_phase == PH_ACT) && (v_phase == PH_ACT);
    assign Pix_tick    = tick;
    assign Line_end    = h_wrap;
    assign Frame_start = fs_q && En && !Rst;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: reduced raster on one instance,
// default 640x480 timing on a second.
module tb_vga_timing_gen;

    localparam int W = 11;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         En = 1'b1;
    logic         Rst2 = 1'b1;
    logic         En2 = 1'b1;

    logic [W-1:0] Count_h, Count_v;
    logic         H_sync, V_sync, Active, Pix_tick, Line_end, Frame_start;

    logic [W-1:0] d_count_h, d_count_v;
    logic         d_h_sync, d_v_sync, d_active, d_pix_tick, d_line_end, d_frame_start;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // reference raster state for the reduced instance
    int m_h = 0;
    int m_v = 0;
    int m_div = 0;
    bit m_fs = 1'b0;

    vga_timing_gen #(
        .REZ_MAX_WIDTH (W),
        .CLK_DIV       (2),
        .H_SYNC        (2),
        .H_BP          (2),
        .H_ACTIVE      (4),
        .H_FP          (2),
        .V_SYNC        (1),
        .V_BP          (1),
        .V_ACTIVE      (3),
        .V_FP          (1),
        .SYNC_POL      (1'b0)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .En          (En),
        .Count_h     (Count_h),
        .Count_v     (Count_v),
        .H_sync      (H_sync),
        .V_sync      (V_sync),
        .Active      (Active),
        .Pix_tick    (Pix_tick),
        .Line_end    (Line_end),
        .Frame_start (Frame_start)
    );

    vga_timing_gen dut_def (
        .Clk         (Clk),
        .Rst         (Rst2),
        .En          (En2),
        .Count_h     (d_count_h),
        .Count_v     (d_count_v),
        .H_sync      (d_h_sync),
        .V_sync      (d_v_sync),
        .Active      (d_active),
        .Pix_tick    (d_pix_tick),
        .Line_end    (d_line_end),
        .Frame_start (d_frame_start)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk_step();
        @(posedge Clk);
        if (Rst) begin
            m_h = 0; m_v = 0; m_div = 0; m_fs = 1'b0;
        end else if (En) begin
            m_fs = 1'b0;
            if (m_div == 1) begin
                m_div = 0;
                if (m_h == 9) begin
                    m_h = 0;
                    if (m_v == 5) begin
                        m_v = 0;
                        m_fs = 1'b1;
                    end else begin
                        m_v++;
                    end
                end else begin
                    m_h++;
                end
            end else begin
                m_div++;
            end
        end else begin
            m_fs = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        En = 1'b1;
        repeat (4) begin
            clk_step();
            n_checks++;
            if ({Count_h, Count_v, H_sync, V_sync, Active,
                 Pix_tick, Line_end, Frame_start} !== {W'(0), W'(0), 6'b0}) begin
                n_fail++;
                $display("FAIL reset_state: h=%0d v=%0d hs=%b vs=%b act=%b pt=%b le=%b fs=%b, want all 0",
                         Count_h, Count_v, H_sync, V_sync, Active,
                         Pix_tick, Line_end, Frame_start);
            end
        end
        Rst = 1'b0;
        #1;
        n_checks++;
        if ({Count_h, Pix_tick, Line_end, Frame_start} !== {W'(0), 3'b0}) begin
            n_fail++;
            $display("FAIL reset_release: h=%0d pt=%b le=%b fs=%b, want 0/0/0/0",
                     Count_h, Pix_tick, Line_end, Frame_start);
        end
        clk_step();
        n_checks++;
        if (Count_h !== W'(0) || Pix_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL first_tick: h=%0d pt=%b, want h=0 pt=1", Count_h, Pix_tick);
        end
        clk_step();
        n_checks++;
        if (Count_h !== W'(1) || Pix_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL first_incr: h=%0d pt=%b, want h=1 pt=0", Count_h, Pix_tick);
        end
    endtask

    task automatic test_free_run();
        logic [W-1:0] eh, ev;
        logic ehs, evs, eact, ept, ele, efs;
        for (int i = 0; i < 200; i++) begin
            clk_step();
            eh   = W'(m_h);
            ev   = W'(m_v);
            ehs  = !(m_h < 2);
            evs  = !(m_v < 1);
            eact = (m_h >= 4 && m_h < 8 && m_v >= 2 && m_v < 5);
            ept  = (m_div == 1);
            ele  = ept && (m_h == 9);
            efs  = m_fs;
            n_checks++;
            if ({Count_h, Count_v, H_sync, V_sync, Active, Pix_tick, Line_end, Frame_start}
                !== {eh, ev, ehs, evs, eact, ept, ele, efs}) begin
                n_fail++;
                $display("FAIL free_run cyc %0d: got h=%0d v=%0d hs=%b vs=%b act=%b pt=%b le=%b fs=%b want h=%0d v=%0d hs=%b vs=%b act=%b pt=%b le=%b fs=%b",
                         cyc, Count_h, Count_v, H_sync, V_sync, Active, Pix_tick, Line_end, Frame_start,
                         eh, ev, ehs, evs, eact, ept, ele, efs);
            end
        end
    endtask

    task automatic test_line_wrap();
        bit pend = 1'b0;
        int pv = 0;
        int fs_n = 0;
        int fs_t0 = 0;
        int fs_t1 = 0;
        for (int i = 0; i < 260; i++) begin
            clk_step();
            if (Frame_start === 1'b1) begin
                if (fs_n == 0) fs_t0 = cyc;
                if (fs_n == 1) fs_t1 = cyc;
                fs_n++;
            end
            if (Line_end === 1'b1) begin
                n_checks++;
                if (Count_h !== W'(9) || Pix_tick !== 1'b1) begin
                    n_fail++;
                    $display("FAIL line_end_pos: h=%0d pt=%b, want h=9 pt=1", Count_h, Pix_tick);
                end
                pend = 1'b1;
                pv = int'(Count_v);
            end else if (pend) begin
                pend = 1'b0;
                n_checks++;
                if (Count_h !== W'(0) || Count_v !== W'((pv + 1) % 6) ||
                    Frame_start !== (pv == 5)) begin
                    n_fail++;
                    $display("FAIL line_wrap: h=%0d v=%0d fs=%b, want h=0 v=%0d fs=%b",
                             Count_h, Count_v, Frame_start, (pv + 1) % 6, (pv == 5));
                end
            end
        end
        n_checks++;
        if (fs_n < 2 || (fs_t1 - fs_t0) != 120) begin
            n_fail++;
            $display("FAIL frame_period: pulses=%0d period=%0d, want >=2 and 120",
                     fs_n, fs_t1 - fs_t0);
        end
    endtask

    task automatic test_enable_hold();
        bit found = 1'b0;
        logic [W-1:0] hh, hv;
        logic hhs, hvs, hact;
        for (int i = 0; i < 60 && !found; i++) begin
            clk_step();
            if (Count_h === W'(5) && Pix_tick === 1'b0) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL enable_wait: Count_h=5 not reached, h=%0d", Count_h);
        end
        En = 1'b0;
        #1;
        hh = Count_h; hv = Count_v; hhs = H_sync; hvs = V_sync; hact = Active;
        n_checks++;
        if ({Pix_tick, Line_end, Frame_start} !== 3'b000) begin
            n_fail++;
            $display("FAIL enable_off_strobes: pt=%b le=%b fs=%b, want 000",
                     Pix_tick, Line_end, Frame_start);
        end
        repeat (10) begin
            clk_step();
            n_checks++;
            if ({Count_h, Count_v, H_sync, V_sync, Active, Pix_tick, Line_end, Frame_start}
                !== {W'(5), hv, hhs, hvs, hact, 3'b000} || hh !== W'(5)) begin
                n_fail++;
                $display("FAIL enable_hold: h=%0d v=%0d hs=%b vs=%b act=%b pt=%b le=%b fs=%b, want h=5 v=%0d hs=%b vs=%b act=%b no strobes",
                         Count_h, Count_v, H_sync, V_sync, Active, Pix_tick, Line_end, Frame_start,
                         hv, hhs, hvs, hact);
            end
        end
        En = 1'b1;
        clk_step();
        n_checks++;
        if (Count_h !== W'(5) || Pix_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_resume1: h=%0d pt=%b, want h=5 pt=1", Count_h, Pix_tick);
        end
        clk_step();
        n_checks++;
        if (Count_h !== W'(6) || Count_v !== hv || Count_h !== W'(m_h)) begin
            n_fail++;
            $display("FAIL enable_resume2: h=%0d v=%0d, want h=6 v=%0d", Count_h, Count_v, hv);
        end
    endtask

    task automatic test_mid_reset();
        bit found = 1'b0;
        int fs_seen = 0;
        for (int i = 0; i < 150 && !found; i++) begin
            clk_step();
            if (Count_h === W'(6) && Count_v === W'(3)) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_reset_wait: (6,3) not reached, h=%0d v=%0d", Count_h, Count_v);
        end
        Rst = 1'b1;
        #1;
        n_checks++;
        if ({Pix_tick, Line_end, Frame_start} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset_strobes: pt=%b le=%b fs=%b, want 000",
                     Pix_tick, Line_end, Frame_start);
        end
        clk_step();
        n_checks++;
        if ({Count_h, Count_v, H_sync, V_sync, Active, Pix_tick, Line_end, Frame_start}
            !== {W'(0), W'(0), 6'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_state: h=%0d v=%0d hs=%b vs=%b act=%b pt=%b le=%b fs=%b, want all 0",
                     Count_h, Count_v, H_sync, V_sync, Active, Pix_tick, Line_end, Frame_start);
        end
        Rst = 1'b0;
        repeat (100) begin
            clk_step();
            if (Frame_start === 1'b1) fs_seen++;
        end
        n_checks++;
        if (fs_seen != 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_fs: Frame_start pulses=%0d, want 0", fs_seen);
        end
    endtask

    task automatic test_default_params();
        int hs_low = 0;
        int le_n = 0;
        int act_n = 0;
        bit found = 1'b0;
        Rst2 = 1'b0;
        #1;
        for (int i = 0; i < 1600; i++) begin
            if (d_h_sync === 1'b0) hs_low++;
            if (d_line_end === 1'b1) le_n++;
            clk_step();
        end
        n_checks++;
        if (hs_low != 192 || le_n != 1) begin
            n_fail++;
            $display("FAIL default_hsync: low=%0d line_ends=%0d, want 192 and 1", hs_low, le_n);
        end
        for (int i = 0; i < 60000 && !found; i++) begin
            clk_step();
            if (d_count_v === W'(35) && d_count_h === W'(0)) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL default_wait: line 35 not reached, v=%0d", d_count_v);
        end
        for (int i = 0; i < 1600; i++) begin
            if (d_active === 1'b1) act_n++;
            clk_step();
        end
        n_checks++;
        if (act_n != 1280) begin
            n_fail++;
            $display("FAIL default_active: high=%0d, want 1280", act_n);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_line_wrap();
        test_enable_hold();
        test_mid_reset();
        test_default_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
